// File: rtl/banner_bitmap_reader.sv
// Scaled monochrome banner overlay: maps scan coordinates onto a packed bitmap
// through a two-stage pipeline, with a frame-synchronous origin update and blink control.
module banner_bitmap_reader #(
    parameter int BMP_W        = 264,
    parameter int BMP_H        = 24,
    parameter int SCALE_LOG2   = 1,
    parameter int COORD_W      = 10,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BMP_W*BMP_H-1:0]   bitmap,
    input  logic                     scan_valid,
    input  logic [COORD_W-1:0]       scan_x,
    input  logic [COORD_W-1:0]       scan_y,
    input  logic                     pos_valid,
    output logic                     pos_ready,
    input  logic [COORD_W-1:0]       pos_x,
    input  logic [COORD_W-1:0]       pos_y,
    input  logic                     blink_en,
    output logic                     pix_valid,
    output logic                     pix_on,
    output logic                     in_box
);

    localparam int COL_W = (BMP_W > 1) ? $clog2(BMP_W) : 1;
    localparam int ROW_W = (BMP_H > 1) ? $clog2(BMP_H) : 1;
    localparam int IDX_W = (BMP_W * BMP_H > 1) ? $clog2(BMP_W * BMP_H) : 1;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [COORD_W:0] BOX_W    = (COORD_W + 1)'(BMP_W << SCALE_LOG2);
    localparam logic [COORD_W:0] BOX_H    = (COORD_W + 1)'(BMP_H << SCALE_LOG2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    localparam logic [1:0] STEADY = 2'd0;
    localparam logic [1:0] SHOW   = 2'd1;
    localparam logic [1:0] HIDE   = 2'd2;

    logic [COORD_W-1:0] org_x, org_y;
    logic [COORD_W-1:0] shadow_x, shadow_y;
    logic               pending;
    logic               frame_start;
    logic [COORD_W-1:0] eff_x, eff_y;
    logic [COORD_W:0]   dx, dy;
    logic               box_c;

    logic               s1_valid, s1_box;
    logic [COL_W-1:0]   s1_col;
    logic [ROW_W-1:0]   s1_row;
    logic [IDX_W-1:0]   idx;
    logic               sel;

    logic [1:0]         state;
    logic [CNT_W-1:0]   count;
    logic               visible;

    assign frame_start = scan_valid && (scan_x == '0) && (scan_y == '0);
    assign pos_ready   = !pending;

    // The frame-start pixel already belongs to the new frame, so it sees the shadow origin.
    assign eff_x = (frame_start && pending) ? shadow_x : org_x;
    assign eff_y = (frame_start && pending) ? shadow_y : org_y;

    assign dx = {1'b0, scan_x} - {1'b0, eff_x};
    assign dy = {1'b0, scan_y} - {1'b0, eff_y};
    assign box_c = scan_valid && !dx[COORD_W] && !dy[COORD_W] && (dx < BOX_W) && (dy < BOX_H);

    always_ff @(posedge clk) begin
        if (rst) begin
            org_x    <= '0;
            org_y    <= '0;
            shadow_x <= '0;
            shadow_y <= '0;
            pending  <= 1'b0;
        end else if (frame_start && pending) begin
            org_x   <= shadow_x;
            org_y   <= shadow_y;
            pending <= 1'b0;
        end else if (pos_valid && !pending) begin
            shadow_x <= pos_x;
            shadow_y <= pos_y;
            pending  <= 1'b1;
        end
    end

    // Row/column are zeroed outside the box so the bitmap index always stays in range.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_box   <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
        end else begin
            s1_valid <= scan_valid;
            s1_box   <= box_c;
            s1_col   <= box_c ? COL_W'(dx >> SCALE_LOG2) : '0;
            s1_row   <= box_c ? ROW_W'(dy >> SCALE_LOG2) : '0;
        end
    end

    assign idx     = IDX_W'(s1_row) * IDX_W'(BMP_W) + IDX_W'(BMP_W - 1) - IDX_W'(s1_col);
    assign sel     = s1_box && bitmap[idx];
    assign visible = (state != HIDE);

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_on    <= 1'b0;
            in_box    <= 1'b0;
        end else begin
            pix_valid <= s1_valid;
            pix_on    <= sel && visible;
            in_box    <= s1_box;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STEADY;
            count <= '0;
        end else if (frame_start) begin
            case (state)
                STEADY: begin
                    if (blink_en) begin
                        state <= SHOW;
                        count <= '0;
                    end
                end
                SHOW, HIDE: begin
                    if (!blink_en) begin
                        state <= STEADY;
                    end else if (count == CNT_LAST) begin
                        state <= (state == SHOW) ? HIDE : SHOW;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= STEADY;
                    count <= '0;
                end
            endcase
        end
    end

endmodule
